// File: rtl/display_bcd_if.sv
// display_bcd_if: conversion request and 7-segment result bundle for display_bcd_driver
interface display_bcd_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
);
    logic                   start_i;
    logic [WIDTH-1:0]       value_i;
    logic                   signed_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   overflow_o;
    logic [DIGITS-1:0][6:0] display_o;
    modport master (output start_i, value_i, signed_i, input busy_o, done_o, overflow_o, display_o);
    modport slave (input start_i, value_i, signed_i, output busy_o, done_o, overflow_o, display_o);
endinterface

// File: rtl/display_bcd_driver.sv
// display_bcd_driver: serial double-dabble binary-to-BCD conversion driving 7-segment digits
module display_bcd_driver #(
    parameter int WIDTH       = 32,
    parameter int DIGITS      = 8,
    parameter int ACTIVE_LOW  = 1,
    parameter int BLANK_ZEROS = 1
) (
    input logic           clk_i,
    input logic           rst_i,
    display_bcd_if.slave  bus
);
    localparam int BCD = (WIDTH * 302) / 1000 + 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [6:0] BLANK = ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
    localparam logic [6:0] DASH = 7'h40;
    localparam logic [6:0] LET_E = 7'h79;
    typedef enum logic [1:0] {IDLE, CONVERT, FORMAT} state_t;
    state_t                 state_q;
    logic [WIDTH-1:0]       sh_q;
    logic [4*BCD-1:0]       bcd_q;
    logic [4*BCD-1:0]       adj_d;
    logic [CW-1:0]          cnt_q;
    logic                   neg_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ovf_q;
    logic                   ovf_d;
    logic [DIGITS-1:0][6:0] disp_q;
    logic [DIGITS-1:0][6:0] disp_d;
    logic [DIGITS-1:0][6:0] lit_d;
    logic                   neg_in;
    logic [WIDTH-1:0]       mag_in;
    int                     msd;
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction
    assign neg_in = bus.signed_i & bus.value_i[WIDTH-1];
    assign mag_in = neg_in ? -bus.value_i : bus.value_i;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.overflow_o = ovf_q;
    assign bus.display_o = disp_q;
    // Add-3 correction applied to every BCD nibble before the shift.
    always_comb begin
        adj_d = bcd_q;
        for (int i = 0; i < BCD; i++)
            adj_d[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    // Turn the finished BCD value into glyphs: blanking, sign placement, overflow, polarity.
    always_comb begin
        msd = 0;
        ovf_d = 1'b0;
        lit_d = '0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_q[4*i +: 4] != 4'd0) msd = i;
        for (int i = 0; i < BCD; i++)
            if ((i >= DIGITS || (neg_q && i >= DIGITS - 1)) && bcd_q[4*i +: 4] != 4'd0) ovf_d = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            lit_d[i] = ovf_d ? (i == 0 ? LET_E : 7'h00) :
                       BLANK_ZEROS == 0 ? (neg_q && i == DIGITS - 1 ? DASH : glyph(bcd_q[4*i +: 4])) :
                       i <= msd ? glyph(bcd_q[4*i +: 4]) :
                       (neg_q && i == msd + 1) ? DASH : 7'h00;
            disp_d[i] = ACTIVE_LOW != 0 ? ~lit_d[i] : lit_d[i];
        end
    end
    // Control FSM: capture on Start, shift one bit per clock, then latch the formatted result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= {DIGITS{BLANK}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        neg_q   <= neg_in;
                        sh_q    <= mag_in;
                        bcd_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd_q, sh_q} <= {adj_d, sh_q} << 1;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= FORMAT;
                end
                FORMAT: begin
                    disp_q  <= disp_d;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_display_bcd_driver.sv
// tb_display_bcd_driver: directed checks of conversion timing, formatting and control
module tb_display_bcd_driver;
    localparam logic [6:0] BL = 7'h7F, DA = 7'h3F, EE = 7'h06;
    localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19;
    localparam logic [6:0] G5 = 7'h12, G7 = 7'h78, G9 = 7'h10;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc;
    int bcnt;
    int seen;
    display_bcd_if #(.WIDTH(32), .DIGITS(8)) b0 ();
    display_bcd_if #(.WIDTH(32), .DIGITS(8)) b1 ();
    display_bcd_driver #(.WIDTH(32), .DIGITS(8), .ACTIVE_LOW(1), .BLANK_ZEROS(1)) dut0 (.clk_i(clk), .rst_i(rst), .bus(b0));
    display_bcd_driver #(.WIDTH(32), .DIGITS(8), .ACTIVE_LOW(1), .BLANK_ZEROS(0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic st, input logic [31:0] v, input logic s);
        b0.start_i = st; b0.value_i = v; b0.signed_i = s;
        b1.start_i = st; b1.value_i = v; b1.signed_i = s;
    endtask
    task automatic go(input logic [31:0] v, input logic s);
        drive(1'b1, v, s);
        @(negedge clk);
        drive(1'b0, v, s);
    endtask
    task automatic wait_done(output int c, output int bc);
        c = 0;
        bc = 0;
        while (!b0.done_o && c < 100) begin
            if (b0.busy_o) bc++;
            @(negedge clk);
            c++;
        end
    endtask
    initial begin
        drive(1'b0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(b0.busy_o), 64'd0);
        check("rst_done", 64'(b0.done_o), 64'd0);
        check("rst_ovf", 64'(b0.overflow_o), 64'd0);
        check("rst_disp", 64'(b0.display_o), 64'({8{BL}}));
        go(32'd1234, 1'b0);
        check("t1_busy_start", 64'(b0.busy_o), 64'd1);
        wait_done(cyc, bcnt);
        check("t1_latency", 64'(cyc), 64'd33);
        check("t1_busy_cycles", 64'(bcnt), 64'd33);
        check("t1_busy_at_done", 64'(b0.busy_o), 64'd0);
        check("t1_disp", 64'(b0.display_o), 64'({BL, BL, BL, BL, G1, G2, G3, G4}));
        check("t1_ovf", 64'(b0.overflow_o), 64'd0);
        @(negedge clk);
        check("t1_done_one_cycle", 64'(b0.done_o), 64'd0);
        check("t1_disp_hold", 64'(b0.display_o), 64'({BL, BL, BL, BL, G1, G2, G3, G4}));
        go(32'd0, 1'b0);
        wait_done(cyc, bcnt);
        check("t2_disp", 64'(b0.display_o), 64'({BL, BL, BL, BL, BL, BL, BL, G0}));
        check("t2_ovf", 64'(b0.overflow_o), 64'd0);
        @(negedge clk);
        go(32'hFFFF_FFD3, 1'b1);
        wait_done(cyc, bcnt);
        check("t3_disp", 64'(b0.display_o), 64'({BL, BL, BL, BL, BL, DA, G4, G5}));
        check("t3_ovf", 64'(b0.overflow_o), 64'd0);
        @(negedge clk);
        go(32'd100000000, 1'b0);
        wait_done(cyc, bcnt);
        check("t4_ovf", 64'(b0.overflow_o), 64'd1);
        check("t4_disp", 64'(b0.display_o), 64'({BL, BL, BL, BL, BL, BL, BL, EE}));
        @(negedge clk);
        go(32'd99999999, 1'b0);
        wait_done(cyc, bcnt);
        check("t4_max_ovf", 64'(b0.overflow_o), 64'd0);
        check("t4_max_disp", 64'(b0.display_o), 64'({G9, G9, G9, G9, G9, G9, G9, G9}));
        go(32'd5, 1'b0);
        check("b2b_accept", 64'(b0.busy_o), 64'd1);
        wait_done(cyc, bcnt);
        check("b2b_latency", 64'(cyc), 64'd33);
        check("b2b_disp", 64'(b0.display_o), 64'({BL, BL, BL, BL, BL, BL, BL, G5}));
        @(negedge clk);
        go(-32'sd10000000, 1'b1);
        wait_done(cyc, bcnt);
        check("neg_ovf", 64'(b0.overflow_o), 64'd1);
        check("neg_ovf_disp", 64'(b0.display_o), 64'({BL, BL, BL, BL, BL, BL, BL, EE}));
        @(negedge clk);
        go(-32'sd9999999, 1'b1);
        wait_done(cyc, bcnt);
        check("neg_max_ovf", 64'(b0.overflow_o), 64'd0);
        check("neg_max_disp", 64'(b0.display_o), 64'({DA, G9, G9, G9, G9, G9, G9, G9}));
        @(negedge clk);
        go(32'd1234, 1'b0);
        repeat (9) @(negedge clk);
        go(32'd5678, 1'b0);
        wait_done(cyc, bcnt);
        check("t5_ignore_latency", 64'(cyc), 64'd23);
        check("t5_ignore_disp", 64'(b0.display_o), 64'({BL, BL, BL, BL, G1, G2, G3, G4}));
        @(negedge clk);
        go(32'd4321, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_busy", 64'(b0.busy_o), 64'd0);
        check("t5_rst_disp", 64'(b0.display_o), 64'({8{BL}}));
        check("t5_rst_ovf", 64'(b0.overflow_o), 64'd0);
        seen = 0;
        repeat (40) begin
            if (b0.done_o || b0.busy_o) seen++;
            @(negedge clk);
        end
        check("t5_no_done_after_rst", 64'(seen), 64'd0);
        go(32'd7, 1'b0);
        wait_done(cyc, bcnt);
        check("t6_zeros_disp", 64'(b1.display_o), 64'({G0, G0, G0, G0, G0, G0, G0, G7}));
        check("t6_blank_disp", 64'(b0.display_o), 64'({BL, BL, BL, BL, BL, BL, BL, G7}));
        @(negedge clk);
        go(32'hFFFF_FFFF, 1'b1);
        wait_done(cyc, bcnt);
        check("t6_neg_disp", 64'(b1.display_o), 64'({DA, G0, G0, G0, G0, G0, G0, G1}));
        check("t6_neg_ovf", 64'(b1.overflow_o), 64'd0);
        @(negedge clk);
        go(32'd100000000, 1'b0);
        wait_done(cyc, bcnt);
        check("t6_ovf_disp", 64'(b1.display_o), 64'({BL, BL, BL, BL, BL, BL, BL, EE}));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
